// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_div_signfix.sv
// Conditional two's-complement negation, used for operand magnitude and result sign fixup.
// Latency: combinational.
// Backpressure: none.
module mul_div_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiply / restoring divide; signed mode when MUL_DIV_SIGNED_EN is defined.
// Latency: Done strobes WIDTH+1 cycles after the Start edge; Result/DivZero held until next Done.
// Backpressure: none; Start is only sampled in IDLE and dropped otherwise.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               Start,
  input  logic               Op,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Result,
  output logic               DivZero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] p_q;
  logic               last;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, shifted, sub_dif;
  logic [2*WIDTH-1:0] step_p, fix_p, fin_p;

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (Start) state_nxt = ST_CALC;
      ST_CALC: if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == ST_CALC);
    Done = (state == ST_DONE);
  end

  // p_q holds {acc/remainder, multiplier/quotient}; m_q is multiplicand or divisor magnitude.
  always_comb begin
    add_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    shifted = p_q[2*WIDTH-1:WIDTH-1];
    sub_dif = shifted - {1'b0, m_q};
    if (op_q == OP_MUL)
      step_p = {add_sum, p_q[WIDTH-1:1]};
    else if (!sub_dif[WIDTH])
      step_p = {sub_dif[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    else
      step_p = {shifted[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
  end

`ifdef MUL_DIV_SIGNED_EN
  logic               sa_in, sb_in, sa_q, sb_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign sa_in = Signed & A[WIDTH-1];
  assign sb_in = Signed & B[WIDTH-1];

  mul_div_signfix #(.W(WIDTH))   u_abs_a   (.x(A), .neg(sa_in), .y(a_mag));
  mul_div_signfix #(.W(WIDTH))   u_abs_b   (.x(B), .neg(sb_in), .y(b_mag));
  mul_div_signfix #(.W(2*WIDTH)) u_fix_prd (.x(step_p), .neg(sa_q ^ sb_q), .y(prod_fix));
  mul_div_signfix #(.W(WIDTH))   u_fix_quo (.x(step_p[WIDTH-1:0]), .neg(sa_q ^ sb_q), .y(quo_fix));
  mul_div_signfix #(.W(WIDTH))   u_fix_rem (.x(step_p[2*WIDTH-1:WIDTH]), .neg(sa_q), .y(rem_fix));

  assign fix_p = (op_q == OP_MUL) ? prod_fix : {rem_fix, quo_fix};

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (state == ST_IDLE && Start) begin
      sa_q <= sa_in;
      sb_q <= sb_in;
    end
  end
`else
  logic signed_unused;

  assign signed_unused = Signed;
  assign a_mag         = A;
  assign b_mag         = B;
  assign fix_p         = step_p;
`endif

  // Divide by zero bypasses the iteration result but still takes full latency.
  assign fin_p = (op_q == OP_DIV && m_q == '0) ? {a_q, {WIDTH{1'b1}}} : fix_p;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      cnt     <= '0;
      op_q    <= OP_MUL;
      a_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      Result  <= '0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (Start) begin
            op_q <= Op;
            a_q  <= A;
            m_q  <= b_mag;
            p_q  <= {{WIDTH{1'b0}}, a_mag};
          end
        end
        ST_CALC: begin
          p_q <= step_p;
          cnt <= cnt + CW'(1);
          if (last) begin
            Result  <= fin_p;
            DivZero <= (op_q == OP_DIV) && (m_q == '0);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results queued at Start, checked at Done.
// Signed expectations follow MUL_DIV_SIGNED_EN so the same bench serves both builds.
module tb_mul_div_unit;

  typedef struct {
    logic [63:0] res;
    logic        dz;
  } exp_t;

  logic        core_clk = 1'b0;
  logic        clr      = 1'b1;
  logic        start    = 1'b0;
  logic        op       = 1'b0;
  logic        sgn      = 1'b0;
  logic [31:0] a        = '0;
  logic [31:0] b        = '0;
  logic        busy, done, divzero;
  logic [63:0] result;

  exp_t        sb_q[$];
  logic [63:0] last_res = '0;
  int          n_chk    = 0;
  int          n_pass   = 0;

  always #5 core_clk = ~core_clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .Clock  (core_clk),
    .Clear  (clr),
    .Start  (start),
    .Op     (op),
    .Signed (sgn),
    .A      (a),
    .B      (b),
    .Busy   (busy),
    .Done   (done),
    .Result (result),
    .DivZero(divzero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic m_op, input logic m_sgn,
                                        input logic [31:0] ma, input logic [31:0] mb,
                                        output logic dz);
    logic               s;
    logic signed [63:0] sa64, sb64;
    logic signed [31:0] sa32, sb32, q, rm;
    logic [63:0]        r;
`ifdef MUL_DIV_SIGNED_EN
    s = m_sgn;
`else
    s = 1'b0;
`endif
    dz = 1'b0;
    sa64 = {{32{ma[31]}}, ma};
    sb64 = {{32{mb[31]}}, mb};
    sa32 = ma;
    sb32 = mb;
    if (m_op == 1'b0) begin
      if (s) r = sa64 * sb64;
      else   r = {32'h0, ma} * {32'h0, mb};
    end else if (mb == 32'h0) begin
      r  = {ma, 32'hFFFF_FFFF};
      dz = 1'b1;
    end else if (s) begin
      if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
        r = {32'h0, 32'h8000_0000};
      end else begin
        q  = sa32 / sb32;
        rm = sa32 % sb32;
        r  = {rm, q};
      end
    end else begin
      r = {ma % mb, ma / mb};
    end
    return r;
  endfunction

  // Caller positions time just after a negedge; Start is sampled on the next posedge.
  task automatic run_op(input string tag, input logic t_op, input logic t_sgn,
                        input logic [31:0] ta, input logic [31:0] tb_v);
    exp_t e;
    logic dz;
    bit   seen;
    e.res = model(t_op, t_sgn, ta, tb_v, dz);
    e.dz  = dz;
    start = 1'b1; op = t_op; sgn = t_sgn; a = ta; b = tb_v;
    sb_q.push_back(e);
    @(posedge core_clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge core_clk);
      // Scramble inputs (including stray Start) to show the running op is latched.
      a     = $urandom;
      b     = $urandom;
      op    = 1'($urandom);
      sgn   = 1'($urandom);
      start = (cyc < 32) ? 1'($urandom) : 1'b0;
      if (cyc == 1)  check({tag, ".busy1"}, 64'(busy), 64'd1);
      if (cyc == 16) check({tag, ".hold"}, result, last_res);
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
        e = sb_q.pop_front();
        check({tag, ".lat"}, 64'(cyc), 64'd33);
        check({tag, ".res"}, result, e.res);
        check({tag, ".dz"}, 64'(divzero), 64'(e.dz));
        check({tag, ".busy0"}, 64'(busy), 64'd0);
        last_res = e.res;
      end
    end
    if (!seen) begin
      check({tag, ".timeout"}, 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    #1;
    check("rst.out", {result, 4'(0)} , {64'h0, 4'(0)});
    check("rst.ctl", {62'h0, busy, done}, 64'h0);
    repeat (3) @(negedge core_clk);
    clr = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge core_clk);
      check("idle", {result ^ 64'h0, 4'(0)} == 68'h0 && !busy && !done && !divzero ? 64'd1 : 64'd0, 64'd1);
    end

    @(negedge core_clk);
    run_op("mul_u",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
    // Back-to-back: Start on the IDLE cycle right after DONE.
    @(negedge core_clk);
    run_op("div_u",   1'b1, 1'b0, 32'd27, 32'd7);
    @(negedge core_clk);
    run_op("mul_s",   1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
    @(negedge core_clk);
    run_op("div_s",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    @(negedge core_clk);
    run_op("div_z",   1'b1, 1'b0, 32'h0000_1234, 32'd0);
    @(negedge core_clk);
    run_op("mul_dz0", 1'b0, 1'b0, 32'h0000_1234, 32'd0);
    @(negedge core_clk);
    run_op("div_min", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge core_clk);
    run_op("div_zs",  1'b1, 1'b1, 32'h8000_0005, 32'd0);
    @(negedge core_clk);
    run_op("div_ms",  1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9);
    for (int i = 0; i < 8; i++) begin
      repeat (1 + (i % 2)) @(negedge core_clk);
      run_op("rnd", 1'($urandom), 1'($urandom), $urandom, (i == 3) ? 32'd3 : $urandom);
    end

    // Clear ten cycles into a multiply: outputs zero without a clock edge.
    @(negedge core_clk);
    start = 1'b1; op = 1'b0; sgn = 1'b0; a = 32'd1234; b = 32'd5678;
    @(posedge core_clk);
    #1 start = 1'b0;
    repeat (10) @(negedge core_clk);
    clr = 1'b1;
    #1;
    check("clr.res", result, 64'h0);
    check("clr.ctl", {61'h0, busy, done, divzero}, 64'h0);
    #1 clr = 1'b0;
    last_res = '0;
    run_op("post_clr", 1'b0, 1'b0, 32'd7, 32'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge core_clk);
      check("post_idle", {62'h0, busy, done}, 64'h0);
    end
    check("post_hold", result, 64'd63);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; Result is 2*WIDTH bits.
REQ-002 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Clear  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port Start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port Op  input  1  0 = multiply, 1 = divide.
REQ-006 SHALL have port Signed  input  1  1 = two's-complement operands.
REQ-007 SHALL have port A  input  WIDTH  multiplicand / dividend.
REQ-008 SHALL have port B  input  WIDTH  multiplier / divisor.
REQ-009 SHALL have port Busy  output  1  high while iterating.
REQ-010 SHALL have port Done  output  1  one-cycle strobe; drives the HI/LO register Write input.
REQ-011 SHALL have port Result  output  2*WIDTH  multiply: {hi,lo} product; divide: {remainder, quotient}; drives the HI/LO register D input.
REQ-012 SHALL have port DivZero  output  1  valid with Done; divide with B = 0.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; IDLE -> CALC on Start, CALC -> DONE after WIDTH iterations, DONE -> IDLE unconditionally.
REQ-014 SHALL latch Op, Signed, A and B on the edge that samples Start in IDLE; later input changes have no effect on the running operation.
REQ-015 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per CALC cycle, using a log2(WIDTH)+1-bit iteration counter.
REQ-016 SHALL assert Done for exactly one cycle, WIDTH+1 cycles after the Start edge (33 for WIDTH=32); Busy high for the WIDTH cycles in between.
REQ-017 SHALL update Result and DivZero only in the DONE cycle and hold them until the next DONE or Clear.
REQ-018 SHALL ignore Start while in CALC or DONE (no queuing); Start on the IDLE cycle following DONE is accepted.
REQ-019 SHALL, in signed mode, operate on magnitudes and negate the product when the operand signs differ; quotient sign = sign(A) xor sign(B), remainder sign = sign(A).
REQ-020 SHALL, on divide with B = 0, keep full latency and produce Result = {A, all-ones}, DivZero = 1.
REQ-021 SHALL, on signed divide of most-negative by -1, produce quotient = most-negative, remainder = 0, DivZero = 0.
REQ-022 SHALL hold DivZero at 0 for multiply.

Reset
REQ-023 SHALL, on Clear high at any time including mid-CALC, force state IDLE, Result = 0, Busy = 0, Done = 0, DivZero = 0, counter = 0, without waiting for Clock.
REQ-024 SHALL accept Start on the first rising edge after Clear deasserts.

Configuration
REQ-025 SHALL, with macro MUL_DIV_SIGNED_EN defined, implement signed operation per REQ-019/REQ-021.
REQ-026 SHALL, without MUL_DIV_SIGNED_EN, ignore Signed (port retained) and treat all operands as unsigned, with no sign-fixup logic synthesized.

Structure
REQ-027 SHALL take the state encoding, Op encoding (OP_MUL, OP_DIV) and default WIDTH from shared package mul_div_pkg.
REQ-028 SHALL place conditional two's-complement negation (operand absolute value, result fixup) in sub-module mul_div_signfix, instantiated only under MUL_DIV_SIGNED_EN.

Verification
REQ-029 SHALL cover: Clear pulse, no Start -> Result = 0, Busy = 0, Done = 0 for 50 cycles.
REQ-030 SHALL cover: unsigned multiply A = 0xFFFF_FFFF, B = 2 -> Done at cycle 33, Result = 0x0000_0001_FFFF_FFFE.
REQ-031 SHALL cover: unsigned divide A = 27, B = 7 -> Result = 0x0000_0006_0000_0003, DivZero = 0.
REQ-032 SHALL cover: signed multiply A = 0xFFFF_FFFD, B = 5 -> 0xFFFF_FFFF_FFFF_FFF1; signed divide A = 0xFFFF_FFF9, B = 2 -> 0xFFFF_FFFF_FFFF_FFFD.
REQ-033 SHALL cover: divide A = 0x1234, B = 0 -> Result = 0x0000_1234_FFFF_FFFF, DivZero = 1.
REQ-034 SHALL cover: Clear at cycle 10 of a multiply -> immediate zeroed outputs, no Done; new Start next edge completes correctly.
